uart_board: RTL and testbench

UART_BOARD -- requirements
Module: uart_board

---
 rtl/uart_board_pkg.sv | 29 ++
 rtl/uart_tx.sv | 103 ++++++++++
 rtl/uart_board.sv | 209 ++++++++++++++++++++
 tb/tb_uart_board.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_board_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_board_pkg
//  Description : Shared FSM state encoding, default timing constants and a
//                counter-width helper for the uart_board design.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_board_pkg;

    // Serial FSM states, shared by the receiver and the transmitter
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 100 MHz system clock, 9600 baud
    localparam int unsigned C_CLKS_PER_BIT  = 10416;
    // Button must be stable this many clocks when debounce is compiled in
    localparam int unsigned C_DEBOUNCE_CLKS = 50000;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : uart_board_pkg
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 serial transmitter. A start pulse while idle snapshots
//                data and sends start bit, 8 data bits LSB first and a stop
//                bit, each CLKS_PER_BIT clocks. TxD and busy are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_board_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = C_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TxD,
    output logic       busy
);

    localparam int unsigned        C_CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [C_CW-1:0]    C_BIT_LAST = C_CW'(CLKS_PER_BIT - 1);

    uart_state_t       r_state;
    logic [C_CW-1:0]   r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_txd;
    logic              r_busy;

    // Transmit FSM: every bit is held for exactly CLKS_PER_BIT clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    r_cnt <= '0;
                    if (start) begin
                        // Snapshot the byte now so later source updates
                        // cannot disturb the frame in flight
                        r_shift <= data;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_bit   <= 3'd0;
                        r_txd   <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign TxD  = r_txd;
    assign busy = r_busy;

endmodule : uart_tx
`default_nettype wire

// File: rtl/uart_board.sv
`default_nettype none
// ============================================================================
//  Module      : uart_board
//  Description : Full-duplex 8N1 UART board. The receiver stores the last
//                good byte in rx_buf; a button rising edge transmits that
//                byte once through uart_tx. Presses during a frame are
//                ignored. Optional button debounce is compiled in with the
//                macro UART_BOARD_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_board
    import uart_board_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = C_CLKS_PER_BIT,
    parameter int unsigned DEBOUNCE_CLKS = C_DEBOUNCE_CLKS
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    input  logic RxD,
    output logic TxD
);

    localparam int unsigned     C_CW        = cnt_width(CLKS_PER_BIT);
    localparam logic [C_CW-1:0] C_BIT_LAST  = C_CW'(CLKS_PER_BIT - 1);
    localparam logic [C_CW-1:0] C_HALF_LAST = C_CW'((CLKS_PER_BIT / 2) - 1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic r_rxd_s1;
    logic r_rxd_s2;
    logic r_btn_s1;
    logic r_btn_s2;

    // Two-flop synchronizers for both asynchronous inputs. The RxD pair
    // resets to the idle-high line level so leaving reset never looks like
    // a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
        end else begin
            r_rxd_s1 <= RxD;
            r_rxd_s2 <= r_rxd_s1;
            r_btn_s1 <= button;
            r_btn_s2 <= r_btn_s1;
        end
    end

    logic w_rxd;
    assign w_rxd = r_rxd_s2;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    uart_state_t     r_rx_state;
    logic [C_CW-1:0] r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            r_rx_ferr;
    logic [7:0]      r_rx_buf;

    // Receive FSM: verify the start bit at mid-bit, then sample each data
    // bit and the stop bit one bit period apart; only good frames update
    // rx_buf.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_ferr  <= 1'b0;
            r_rx_buf   <= 8'h00;
        end else begin
            case (r_rx_state)
                IDLE: begin
                    r_rx_cnt  <= '0;
                    r_rx_ferr <= 1'b0;
                    if (!w_rxd) begin
                        r_rx_state <= START;
                    end
                end
                START: begin
                    if (r_rx_cnt == C_HALF_LAST) begin
                        r_rx_cnt <= '0;
                        if (!w_rxd) begin
                            r_rx_bit   <= 3'd0;
                            r_rx_state <= DATA;
                        end else begin
                            // Line went back high: a glitch, not a frame
                            r_rx_state <= IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_rx_cnt == C_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_rx_ferr) begin
                        // Framing error: drop the byte and wait for idle
                        // line so the low stop bit is not taken as a start
                        if (w_rxd) begin
                            r_rx_ferr  <= 1'b0;
                            r_rx_state <= IDLE;
                        end
                    end else if (r_rx_cnt == C_BIT_LAST) begin
                        r_rx_cnt <= '0;
                        if (w_rxd) begin
                            r_rx_buf   <= r_rx_shift;
                            r_rx_state <= IDLE;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rx_cnt   <= '0;
                    r_rx_ferr  <= 1'b0;
                    r_rx_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Button qualification
    // ------------------------------------------------------------------
    logic w_btn_lvl;

`ifdef UART_BOARD_DEBOUNCE_EN
    localparam int unsigned     C_DW      = cnt_width(DEBOUNCE_CLKS);
    localparam logic [C_DW-1:0] C_DB_LAST = C_DW'(DEBOUNCE_CLKS - 1);

    logic [C_DW-1:0] r_db_cnt;
    logic            r_db_lvl;

    // Debounce: adopt the synchronized level only after it has differed
    // from the accepted level for DEBOUNCE_CLKS consecutive clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_cnt <= '0;
            r_db_lvl <= 1'b0;
        end else if (r_btn_s2 == r_db_lvl) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == C_DB_LAST) begin
            r_db_cnt <= '0;
            r_db_lvl <= r_btn_s2;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_btn_lvl = r_db_lvl;
`else
    assign w_btn_lvl = r_btn_s2;
`endif

    logic r_btn_prev;

    // Previous qualified level for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_prev <= 1'b0;
        end else begin
            r_btn_prev <= w_btn_lvl;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic w_btn_rise;
    logic w_tx_busy;
    logic w_tx_start;

    // A held button gives one edge; an edge while busy is simply dropped
    assign w_btn_rise = w_btn_lvl & ~r_btn_prev;
    assign w_tx_start = w_btn_rise & ~w_tx_busy;

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (w_tx_start),
        .data  (r_rx_buf),
        .TxD   (TxD),
        .busy  (w_tx_busy)
    );

endmodule : uart_board
`default_nettype wire

// File: tb/tb_uart_board.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_board
//  Description : Directed self-checking bench for uart_board. Uses a short
//                bit period so whole frames run quickly; expected bytes and
//                bit patterns are written out by hand in each scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_board;

    localparam int CPB   = 16;
    localparam int DB    = 40;
    localparam int FRAME = 10 * CPB;
`ifdef UART_BOARD_DEBOUNCE_EN
    localparam int HOLD    = DB + 10;
    localparam int LAT_MAX = DB + 6;
`else
    localparam int HOLD    = 5;
    localparam int LAT_MAX = 4;
`endif
    localparam int WAIT = 2 * FRAME + DB + 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button = 1'b0;
    logic RxD = 1'b1;
    logic TxD;

    int total = 0;
    int bad   = 0;

    uart_board #(
        .CLKS_PER_BIT  (CPB),
        .DEBOUNCE_CLKS (DB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .RxD    (RxD),
        .TxD    (TxD)
    );

    always #5 clk = ~clk;

    // Drive one 8N1 frame on RxD followed by one idle bit time
    task automatic send_byte(input logic [7:0] d, input logic stop_val);
        @(negedge clk) RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop_val;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // Wait (bounded) for a start bit, then sample every bit at its centre
    task automatic capture(output logic [7:0] d, output bit found,
                           output bit fr_ok, output int lat);
        d = 8'h00; found = 1'b0; fr_ok = 1'b0; lat = 0;
        for (int k = 0; k < WAIT && !found; k++) begin
            @(negedge clk);
            lat++;
            if (TxD === 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (CPB / 2) @(negedge clk);
            fr_ok = (TxD === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                d[i] = TxD;
            end
            repeat (CPB) @(negedge clk);
            fr_ok = fr_ok & (TxD === 1'b1);
        end
    endtask

    // Press for HOLD clocks and capture the resulting frame
    task automatic press_capture(output logic [7:0] d, output bit found,
                                 output bit fr_ok, output int lat);
        @(negedge clk) button = 1'b1;
        fork
            begin
                repeat (HOLD) @(negedge clk);
                button = 1'b0;
            end
            capture(d, found, fr_ok, lat);
        join
        repeat (CPB) @(negedge clk);
    endtask

    // Count clocks on which TxD is not idle-high
    task automatic count_lows(input int cycles, output int lows);
        lows = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
    endtask

    // Press and compare the captured frame against an expected byte
    task automatic expect_frame(input string name, input logic [7:0] exp);
        logic [7:0] d; bit f; bit fr; int lat;
        press_capture(d, f, fr, lat);
        total++;
        if (!f || !fr || d !== exp) begin
            bad++;
            $display("FAIL %s: got found=%0b framing=%0b data=0x%02h, need 1/1/0x%02h",
                     name, f, fr, d, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; button = 1'b0; RxD = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (TxD !== 1'b1) begin
            bad++; $display("FAIL reset_txd: got %b, need 1", TxD);
        end
        reset = 1'b0;
        begin
            int lows;
            count_lows(4 * CPB, lows);
            total++;
            if (lows != 0) begin
                bad++; $display("FAIL idle_after_reset: low clocks %0d, need 0", lows);
            end
        end
    endtask

    // No good frame received yet: a press sends 0x00
    task automatic test_empty_press();
        expect_frame("empty_press", 8'h00);
    endtask

    // 0x0A: full bit-by-bit waveform 0,0,1,0,1,0,0,0,0,1 at CPB clocks each
    task automatic test_waveform();
        logic [9:0] exp_bits;
        int lat; bit seen; int errs;
        exp_bits = 10'b10_0001_0100;
        send_byte(8'h0A, 1'b1);
        lat = 0; seen = 1'b0; errs = 0;
        @(negedge clk) button = 1'b1;
        for (int k = 0; k < WAIT && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (TxD === 1'b0) seen = 1'b1;
        end
        total++;
        if (!seen || lat > LAT_MAX) begin
            bad++; $display("FAIL start_latency: seen=%0b clocks=%0d, need 1 and <=%0d",
                            seen, lat, LAT_MAX);
        end
        if (seen) begin
            for (int s = 0; s < FRAME; s++) begin
                if (TxD !== exp_bits[s / CPB]) errs++;
                @(negedge clk);
            end
        end
        button = 1'b0;
        total++;
        if (!seen || errs != 0) begin
            bad++; $display("FAIL waveform_0x0A: wrong samples %0d, need 0", errs);
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_sequence();
        send_byte(8'h0A, 1'b1); expect_frame("seq_0x0A", 8'h0A);
        send_byte(8'h14, 1'b1); expect_frame("seq_0x14", 8'h14);
        send_byte(8'h1E, 1'b1); expect_frame("seq_0x1E", 8'h1E);
    endtask

    // Bad stop bit after a good 0x55 must leave 0x55 in the buffer
    task automatic test_framing();
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b0);
        expect_frame("framing_keep_0x55", 8'h55);
    endtask

    task automatic test_held_and_busy();
        logic [7:0] d; bit f; bit fr; int lat; int lows;
        // Held for three frame times: exactly one frame
        @(negedge clk) button = 1'b1;
        capture(d, f, fr, lat);
        total++;
        if (!f || !fr || d !== 8'h55) begin
            bad++; $display("FAIL held_first: found=%0b data=0x%02h, need 1/0x55", f, d);
        end
        count_lows(3 * FRAME, lows);
        total++;
        if (lows != 0) begin
            bad++; $display("FAIL held_extra_frame: low clocks %0d, need 0", lows);
        end
        button = 1'b0;
        repeat (CPB) @(negedge clk);
        // Second press while the first frame is in flight is dropped
        @(negedge clk) button = 1'b1;
        fork
            begin
                repeat (HOLD) @(negedge clk);
                button = 1'b0;
                repeat (3 * CPB) @(negedge clk);
                button = 1'b1;
                repeat (HOLD) @(negedge clk);
                button = 1'b0;
            end
            capture(d, f, fr, lat);
        join
        total++;
        if (!f || !fr || d !== 8'h55) begin
            bad++; $display("FAIL busy_first: found=%0b data=0x%02h, need 1/0x55", f, d);
        end
        count_lows(2 * FRAME, lows);
        total++;
        if (lows != 0) begin
            bad++; $display("FAIL busy_press_queued: low clocks %0d, need 0", lows);
        end
    endtask

    // Low pulse shorter than half a bit is not a start bit
    task automatic test_glitch();
        @(negedge clk) RxD = 1'b0;
        repeat (CPB / 2 - 3) @(negedge clk);
        RxD = 1'b1;
        repeat (FRAME) @(negedge clk);
        expect_frame("glitch_keep_0x55", 8'h55);
    endtask

    // RX of 0x3C completes while 0x55 is being sent
    task automatic test_full_duplex();
        logic [7:0] d; bit f; bit fr; int lat;
        fork
            send_byte(8'h3C, 1'b1);
            begin
                repeat (30) @(negedge clk);
                press_capture(d, f, fr, lat);
            end
        join
        total++;
        if (!f || !fr || d !== 8'h55) begin
            bad++; $display("FAIL duplex_snapshot: found=%0b data=0x%02h, need 1/0x55", f, d);
        end
        expect_frame("duplex_new_0x3C", 8'h3C);
    endtask

`ifdef UART_BOARD_DEBOUNCE_EN
    task automatic test_debounce();
        int lows;
        @(negedge clk) button = 1'b1;
        repeat (DB - 10) @(negedge clk);
        button = 1'b0;
        count_lows(FRAME, lows);
        total++;
        if (lows != 0) begin
            bad++; $display("FAIL debounce_short: low clocks %0d, need 0", lows);
        end
        expect_frame("debounce_long", 8'h3C);
        count_lows(FRAME, lows);
        total++;
        if (lows != 0) begin
            bad++; $display("FAIL debounce_extra: low clocks %0d, need 0", lows);
        end
    endtask
`endif

    task automatic test_reset_mid_tx();
        bit seen; int lows;
        seen = 1'b0;
        @(negedge clk) button = 1'b1;
        for (int k = 0; k < WAIT && !seen; k++) begin
            @(negedge clk);
            if (TxD === 1'b0) seen = 1'b1;
        end
        button = 1'b0;
        repeat (3 * CPB + 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (!seen || TxD !== 1'b1) begin
            bad++; $display("FAIL reset_mid_tx: started=%0b TxD=%b, need 1/1", seen, TxD);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        count_lows(2 * FRAME, lows);
        total++;
        if (lows != 0) begin
            bad++; $display("FAIL residual_frame: low clocks %0d, need 0", lows);
        end
        expect_frame("after_reset_0x00", 8'h00);
    endtask

    initial begin
        test_reset();
        test_empty_press();
        test_waveform();
        test_sequence();
        test_framing();
        test_held_and_busy();
        test_glitch();
        test_full_duplex();
`ifdef UART_BOARD_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_board
`default_nettype wire
